// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, writeback entry type and address-width helper
package wb_pkg;

  function automatic int addr_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  localparam int DefDataWidth = 16;
  localparam int DefNumRegs   = 16;
  localparam int DefFifoDepth = 4;
  localparam int DefAddrWidth = addr_width(DefNumRegs);

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback entries with per-entry address taps
module wb_fifo
  import wb_pkg::*;
#(
  parameter type entry_t   = wb_entry_t,
  parameter int  AddrWidth = DefAddrWidth,
  parameter int  Depth     = DefFifoDepth
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  entry_t                            push_entry,
  input  logic                              pop,
  output entry_t                            head,
  output logic                              full,
  output logic                              empty,
  output logic [Depth-1:0]                  entry_valid,
  output logic [Depth-1:0][AddrWidth-1:0]   entry_addr
);

  localparam int IdxWidth = $clog2(Depth);
  localparam int PtrWidth = IdxWidth + 1;

  entry_t              mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [PtrWidth-1:0] count;
  logic [IdxWidth-1:0] wr_idx;
  logic [IdxWidth-1:0] rd_idx;

  assign wr_idx = wr_ptr[IdxWidth-1:0];
  assign rd_idx = rd_ptr[IdxWidth-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  // Same slot with differing wrap bits means the writer has lapped the reader.
  assign full   = (wr_idx == rd_idx) && (wr_ptr[IdxWidth] != rd_ptr[IdxWidth]);
  assign head   = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= push_entry;
  end

  for (genvar i = 0; i < Depth; i++) begin : g_tap
    logic [IdxWidth-1:0] offset;
    // Slot distance from the read pointer decides whether the slot holds live data.
    assign offset         = IdxWidth'(i) - rd_idx;
    assign entry_valid[i] = ({1'b0, offset} < count);
    assign entry_addr[i]  = mem[i].addr;
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback arbiter, ALU result buffer and load scoreboard
// Optional register-output forwarding ports enabled by WB_FORWARD_EN.
module writeback_unit
  import wb_pkg::*;
#(
  parameter  int DataWidth = DefDataWidth,
  parameter  int NumRegs   = DefNumRegs,
  parameter  int FifoDepth = DefFifoDepth,
  localparam int AddrWidth = addr_width(NumRegs)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [AddrWidth-1:0] alu_addr,
  input  logic [DataWidth-1:0] alu_data,
  input  logic                 mem_valid,
  input  logic [AddrWidth-1:0] mem_addr,
  input  logic [DataWidth-1:0] mem_data,
  input  logic                 issue_valid,
  input  logic                 issue_load,
  input  logic [AddrWidth-1:0] issue_addr1,
  input  logic [AddrWidth-1:0] issue_addr2,
  input  logic [AddrWidth-1:0] issue_dst,
  output logic                 hazard,
`ifdef WB_FORWARD_EN
  output logic                 fwd1_valid,
  output logic                 fwd2_valid,
  output logic [DataWidth-1:0] fwd_data,
`endif
  output logic [NumRegs-1:0]   pending,
  output logic                 reg_w_en,
  output logic [AddrWidth-1:0] addr_in,
  output logic [DataWidth-1:0] reg_in
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t                              alu_entry;
  entry_t                              fifo_head;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic                                fifo_push;
  logic                                fifo_pop;
  logic                                alu_fire;
  logic                                alu_bypass;
  logic                                issue_fire;
  logic [FifoDepth-1:0]                entry_valid;
  logic [FifoDepth-1:0][AddrWidth-1:0] entry_addr;
  logic [NumRegs-1:0]                  busy;

  assign alu_entry.addr = alu_addr;
  assign alu_entry.data = alu_data;

  // Ready is taken from the registered fullness so a same-cycle pop cannot raise it.
  assign alu_ready  = !fifo_full;
  assign alu_fire   = alu_valid && alu_ready;
  assign fifo_pop   = !mem_valid && !fifo_empty;
  assign alu_bypass = alu_fire && !mem_valid && fifo_empty;
  assign fifo_push  = alu_fire && !alu_bypass;

  wb_fifo #(
    .entry_t   (entry_t),
    .AddrWidth (AddrWidth),
    .Depth     (FifoDepth)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .push_entry  (alu_entry),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_w_en <= 1'b0;
      addr_in  <= '0;
      reg_in   <= '0;
    end else if (mem_valid) begin
      reg_w_en <= 1'b1;
      addr_in  <= mem_addr;
      reg_in   <= mem_data;
    end else if (!fifo_empty) begin
      reg_w_en <= 1'b1;
      addr_in  <= fifo_head.addr;
      reg_in   <= fifo_head.data;
    end else if (alu_fire) begin
      reg_w_en <= 1'b1;
      addr_in  <= alu_addr;
      reg_in   <= alu_data;
    end else begin
      reg_w_en <= 1'b0;
    end
  end

  // Registers with a write still in flight anywhere between producers and the register file.
  always_comb begin
    busy = pending;
    for (int i = 0; i < FifoDepth; i++) begin
      if (entry_valid[i]) busy[entry_addr[i]] = 1'b1;
    end
    if (alu_valid) busy[alu_addr] = 1'b1;
`ifndef WB_FORWARD_EN
    if (reg_w_en) busy[addr_in] = 1'b1;
`endif
  end

  assign hazard     = issue_valid && (busy[issue_addr1] || busy[issue_addr2] || busy[issue_dst]);
  assign issue_fire = issue_valid && !hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        if (mem_valid && mem_addr == AddrWidth'(r)) pending[r] <= 1'b0;
        if (issue_fire && issue_load && issue_dst == AddrWidth'(r)) pending[r] <= 1'b1;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd1_valid = reg_w_en && (addr_in == issue_addr1);
  assign fwd2_valid = reg_w_en && (addr_in == issue_addr2);
  assign fwd_data   = reg_in;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed vector table plus randomized run against a queue model
module tb_writeback_unit;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, mem_valid;
  logic [3:0]  alu_addr, mem_addr, issue_addr1, issue_addr2, issue_dst, addr_in;
  logic [15:0] alu_data, mem_data, reg_in, pending;
  logic        issue_valid, issue_load, hazard, reg_w_en;
`ifdef WB_FORWARD_EN
  logic        fwd1_valid, fwd2_valid;
  logic [15:0] fwd_data;
`endif

  writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_load(issue_load),
    .issue_addr1(issue_addr1), .issue_addr2(issue_addr2), .issue_dst(issue_dst),
    .hazard(hazard),
`ifdef WB_FORWARD_EN
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid), .fwd_data(fwd_data),
`endif
    .pending(pending), .reg_w_en(reg_w_en), .addr_in(addr_in), .reg_in(reg_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [3:0] aa; logic [15:0] ad;
    logic mv; logic [3:0] ma; logic [15:0] md;
    logic iv; logic il; logic [3:0] i1; logic [3:0] i2; logic [3:0] id;
    logic e_rdy; logic e_haz; logic e_wen; logic [3:0] e_addr; logic [15:0] e_data; logic [15:0] e_pend;
  } vec_t;

  typedef struct packed { logic [3:0] a; logic [15:0] d; } ent_t;

  vec_t        vecs [21];
  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        q[$];
  logic [15:0] m_pend;
  logic        m_wen;
  logic [3:0]  m_addr;
  logic [15:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [15:0] md,
                       input logic iv, input logic il, input logic [3:0] i1,
                       input logic [3:0] i2, input logic [3:0] id);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    issue_valid = iv; issue_load = il; issue_addr1 = i1; issue_addr2 = i2; issue_dst = id;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_out(input string tag, input logic wen, input logic [3:0] a,
                           input logic [15:0] d, input logic [15:0] p);
    chk({tag, ".reg_w_en"}, 32'(reg_w_en), 32'(wen));
    chk({tag, ".addr_in"}, 32'(addr_in), 32'(a));
    chk({tag, ".reg_in"}, 32'(reg_in), 32'(d));
    chk({tag, ".pending"}, 32'(pending), 32'(p));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_pend = '0; m_wen = 1'b0; m_addr = '0; m_data = '0;
  endtask

  function automatic logic model_conflict(input logic [3:0] a);
    logic hit;
    hit = m_pend[a] || (alu_valid && alu_addr == a) || (!FWD && m_wen && m_addr == a);
    foreach (q[k]) if (q[k].a == a) hit = 1'b1;
    return hit;
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.alu_ready", 32'(alu_ready), 32'(1));
    chk("reset.hazard", 32'(hazard), 32'(0));
    check_out("reset", 0, 4'h0, 16'h0000, 16'h0000);

    //           av aa  ad       mv ma  md       iv il i1 i2 id  rdy haz   wen addr data     pend
    vecs[0]  = '{1, 3, 16'h1234, 0, 0, 16'h0000, 1, 1, 0, 0, 5,  1, 0,    1, 3,  16'h1234, 16'h0020};
    vecs[1]  = '{1, 2, 16'h0001, 1, 5, 16'hBEEF, 0, 0, 0, 0, 0,  1, 0,    1, 5,  16'hBEEF, 16'h0000};
    vecs[2]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 0,    1, 2,  16'h0001, 16'h0000};
    vecs[3]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 0,    0, 2,  16'h0001, 16'h0000};
    vecs[4]  = '{1, 8, 16'h0808, 1, 1, 16'h1111, 0, 0, 0, 0, 0,  1, 0,    1, 1,  16'h1111, 16'h0000};
    vecs[5]  = '{1, 9, 16'h0909, 1, 1, 16'h1112, 0, 0, 0, 0, 0,  1, 0,    1, 1,  16'h1112, 16'h0000};
    vecs[6]  = '{1, 10, 16'h0A0A, 1, 1, 16'h1113, 0, 0, 0, 0, 0, 1, 0,    1, 1,  16'h1113, 16'h0000};
    vecs[7]  = '{1, 11, 16'h0B0B, 1, 1, 16'h1114, 0, 0, 0, 0, 0, 1, 0,    1, 1,  16'h1114, 16'h0000};
    vecs[8]  = '{1, 12, 16'h0C0C, 1, 1, 16'h1115, 0, 0, 0, 0, 0, 0, 0,    1, 1,  16'h1115, 16'h0000};
    vecs[9]  = '{1, 12, 16'h0C0C, 1, 1, 16'h1116, 0, 0, 0, 0, 0, 0, 0,    1, 1,  16'h1116, 16'h0000};
    vecs[10] = '{1, 12, 16'h0C0C, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0,    1, 8,  16'h0808, 16'h0000};
    vecs[11] = '{1, 12, 16'h0C0C, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0,    1, 9,  16'h0909, 16'h0000};
    vecs[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 0,    1, 10, 16'h0A0A, 16'h0000};
    vecs[13] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 0,    1, 11, 16'h0B0B, 16'h0000};
    vecs[14] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 0,    1, 12, 16'h0C0C, 16'h0000};
    vecs[15] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 0,    0, 12, 16'h0C0C, 16'h0000};
    vecs[16] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0, 7,  1, 0,    0, 12, 16'h0C0C, 16'h0080};
    vecs[17] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 7, 0, 6,  1, 1,    0, 12, 16'h0C0C, 16'h0080};
    vecs[18] = '{0, 0, 16'h0000, 1, 7, 16'h7777, 1, 0, 7, 0, 6,  1, 1,    1, 7,  16'h7777, 16'h0000};
    vecs[19] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 7, 0, 6,  1, !FWD, 0, 7,  16'h7777, 16'h0000};
    vecs[20] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 7, 0, 6,  1, 0,    0, 7,  16'h7777, 16'h0000};

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md,
            vecs[i].iv, vecs[i].il, vecs[i].i1, vecs[i].i2, vecs[i].id);
      #1;
      chk($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.hazard", i), 32'(hazard), 32'(vecs[i].e_haz));
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_pend);
    end

    // Reset while the FIFO holds three results and two loads are outstanding.
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk); drive(1, 2, 16'h0022, 1, 1, 16'h0101, 1, 1, 7, 7, 7);
    @(negedge clk); drive(1, 3, 16'h0033, 1, 1, 16'h0102, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 4, 16'h0044, 1, 1, 16'h0103, 0, 0, 0, 0, 0);
    @(negedge clk); idle();
    #1;
    chk("rstmid.pre_pending", 32'(pending), 32'(16'h0081));
    chk("rstmid.pre_ready", 32'(alu_ready), 32'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_out("rstmid", 0, 4'h0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid.ready", 32'(alu_ready), 32'(1));
    repeat (2) begin
      @(posedge clk); #1;
      check_out("rstmid.nodrain", 0, 4'h0, 16'h0000, 16'h0000);
    end

    // Back-to-back write then read of r4.
    @(negedge clk); drive(1, 4, 16'h4444, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_out("fwd.write", 1, 4'h4, 16'h4444, 16'h0000);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0, 4, 9, 10);
    #1;
    chk("fwd.hazard", 32'(hazard), 32'(!FWD));
`ifdef WB_FORWARD_EN
    chk("fwd.fwd1_valid", 32'(fwd1_valid), 32'(1));
    chk("fwd.fwd2_valid", 32'(fwd2_valid), 32'(0));
    chk("fwd.fwd_data", 32'(fwd_data), 32'(16'h4444));
`endif
    @(posedge clk);
    @(negedge clk); #1;
    chk("fwd.hazard_after", 32'(hazard), 32'(0));

    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic       exp_rdy, exp_haz, fire, found;
      logic [3:0] pick;
      int         start;
      @(negedge clk);
      alu_valid   = ($urandom_range(0, 9) < 6);
      alu_addr    = 4'($urandom_range(0, 15));
      alu_data    = 16'($urandom);
      mem_valid   = ($urandom_range(0, 9) < 3);
      mem_data    = 16'($urandom);
      pick        = 4'($urandom_range(0, 15));
      if (m_pend != 0 && $urandom_range(0, 3) != 0) begin
        start = $urandom_range(0, 15);
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
          if (!found && m_pend[(start + k) % 16]) begin
            pick  = 4'((start + k) % 16);
            found = 1'b1;
          end
        end
      end
      mem_addr    = pick;
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_load  = ($urandom_range(0, 9) < 4);
      issue_addr1 = 4'($urandom_range(0, 15));
      issue_addr2 = 4'($urandom_range(0, 15));
      issue_dst   = 4'($urandom_range(0, 15));
      #1;
      exp_rdy = (q.size() < 4);
      exp_haz = issue_valid && (model_conflict(issue_addr1) || model_conflict(issue_addr2) ||
                                model_conflict(issue_dst));
      chk("rand.alu_ready", 32'(alu_ready), 32'(exp_rdy));
      chk("rand.hazard", 32'(hazard), 32'(exp_haz));
`ifdef WB_FORWARD_EN
      chk("rand.fwd1_valid", 32'(fwd1_valid), 32'(m_wen && m_addr == issue_addr1));
      chk("rand.fwd2_valid", 32'(fwd2_valid), 32'(m_wen && m_addr == issue_addr2));
      chk("rand.fwd_data", 32'(fwd_data), 32'(m_data));
`endif
      fire = alu_valid && exp_rdy;
      if (mem_valid) begin
        m_wen = 1'b1; m_addr = mem_addr; m_data = mem_data;
        m_pend[mem_addr] = 1'b0;
      end else if (q.size() > 0) begin
        ent_t e;
        e = q.pop_front();
        m_wen = 1'b1; m_addr = e.a; m_data = e.d;
      end else if (fire) begin
        m_wen = 1'b1; m_addr = alu_addr; m_data = alu_data;
        fire = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (fire) q.push_back('{alu_addr, alu_data});
      if (issue_valid && !exp_haz && issue_load) m_pend[issue_dst] = 1'b1;
      @(posedge clk); #1;
      check_out("rand", m_wen, m_addr, m_data, m_pend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
